// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 indexed-accumulator sequencer.
//   - 4-bit opcode constants (IR[15:12])
//   - ALU function-select codes driven on alufs
//   - sequencer state encoding
//   - ctrl_t: the datapath/memory control bundle produced by the decoder
package mu0_pkg;

  localparam logic [3:0] OP_LDA    = 4'd0;
  localparam logic [3:0] OP_STO    = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_JMP    = 4'd4;
  localparam logic [3:0] OP_JGE    = 4'd5;
  localparam logic [3:0] OP_JNE    = 4'd6;
  localparam logic [3:0] OP_STP    = 4'd7;
  localparam logic [3:0] OP_MOVI   = 4'd8;
  localparam logic [3:0] OP_MOVIDX = 4'd9;
  localparam logic [3:0] OP_LDIDX  = 4'd10;
  localparam logic [3:0] OP_STIDX  = 4'd11;
  localparam logic [3:0] OP_ADDIDX = 4'd12;
  localparam logic [3:0] OP_SUBIDX = 4'd13;
  localparam logic [3:0] OP_STOIDX = 4'd14;
  localparam logic [3:0] OP_BUBIDX = 4'd15;

  localparam logic [1:0] ALU_PASSB = 2'b00;  // B
  localparam logic [1:0] ALU_INC   = 2'b01;  // A + 1
  localparam logic [1:0] ALU_ADD   = 2'b10;  // A + B
  localparam logic [1:0] ALU_SUB   = 2'b11;  // A - B

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic       asel;
    logic       bsel;
    logic       accce;
    logic       pcce;
    logic       irce;
    logic       accoe;
    logic       memrq;
    logic       rnw;
    logic       idx_en;
    logic       csel;
    logic       idxce;
    logic       idxoe;
    logic       dsel;
    logic [1:0] alufs;
  } ctrl_t;

endpackage

// File: rtl/mu0_seq_decode.sv
// mu0_seq_decode: purely combinational control table.
//   state, opcode, accz, acc15, resume -> ctl (ungated control vector), next_state
// The table assumes memory is ready; wait-state gating and reset forcing are
// applied by the top level.
module mu0_seq_decode
  import mu0_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       accz,
  input  logic       acc15,
  input  logic       resume,
  output ctrl_t      ctl,
  output state_t     next_state
);

  logic taken;

  always_comb begin
    ctl        = '0;
    next_state = state;
    taken      = 1'b0;
    case (state)
      ST_FETCH: begin
        ctl.alufs  = ALU_INC;
        ctl.pcce   = 1'b1;
        ctl.irce   = 1'b1;
        ctl.memrq  = 1'b1;
        ctl.rnw    = 1'b1;
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        ctl.asel   = 1'b1;
        next_state = ST_FETCH;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_LDIDX: begin
            ctl.bsel  = 1'b1;
            ctl.accce = 1'b1;
            ctl.memrq = 1'b1;
            ctl.rnw   = 1'b1;
            ctl.dsel  = (opcode == OP_LDIDX);
            ctl.alufs = (opcode == OP_ADD) ? ALU_ADD :
                        (opcode == OP_SUB) ? ALU_SUB : ALU_PASSB;
          end
          OP_STO, OP_STIDX: begin
            ctl.accoe = 1'b1;
            ctl.memrq = 1'b1;
            ctl.dsel  = (opcode == OP_STIDX);
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            // Fused fetch: a taken jump increments the target held on A,
            // a not-taken one increments the PC; either way IR is reloaded.
            taken = (opcode == OP_JMP) ||
                    (opcode == OP_JGE && !acc15) ||
                    (opcode == OP_JNE && !accz);
            ctl.asel   = taken;
            ctl.alufs  = ALU_INC;
            ctl.pcce   = 1'b1;
            ctl.irce   = 1'b1;
            ctl.memrq  = 1'b1;
            ctl.rnw    = 1'b1;
            next_state = ST_EXEC;
          end
          OP_STP: begin
            ctl.asel   = 1'b0;
            next_state = ST_HALT;
          end
          OP_MOVI: begin
            ctl.accce  = 1'b1;
            ctl.alufs  = ALU_PASSB;
            ctl.idx_en = 1'b1;
          end
          OP_MOVIDX: begin
            ctl.accoe  = 1'b1;
            ctl.idx_en = 1'b1;
            ctl.idxce  = 1'b1;
          end
          OP_ADDIDX, OP_SUBIDX: begin
            ctl.idx_en = 1'b1;
            ctl.idxce  = 1'b1;
            ctl.alufs  = (opcode == OP_ADDIDX) ? ALU_ADD : ALU_SUB;
          end
          OP_STOIDX: begin
            ctl.memrq = 1'b1;
            ctl.idxoe = 1'b1;
          end
          OP_BUBIDX: begin
            // Compare phase; the swap happens in EXEC2.
            ctl.accce  = 1'b1;
            ctl.idx_en = 1'b1;
            next_state = ST_EXEC2;
          end
          default: ;
        endcase
      end
      ST_EXEC2: begin
        ctl.accce  = 1'b1;
        ctl.idx_en = 1'b1;
        ctl.csel   = 1'b1;
        next_state = ST_FETCH;
      end
      ST_HALT: begin
        next_state = resume ? ST_FETCH : ST_HALT;
      end
      default: next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/mu0_seq.sv
// mu0_seq: MU0 control sequencer (FETCH / EXEC / EXEC2 / HALT).
// Parameters: NIDX index registers (power of two, >= 2), CNT_W retire counter width.
// Ports:
//   clk        - state updates on the falling edge, datapath samples on the rising edge
//   reset      - asynchronous, active-low; forces every control to 0 combinationally
//   opcode, ir_idx, accz, acc15 - instruction fields and ACC flags
//   mem_ready  - current memrq access completes this cycle
//   resume     - leave HALT (ignored elsewhere)
//   asel .. dsel, alufs - datapath and memory controls
//   idx_sel    - index register addressed (ir_idx in EXEC/EXEC2, else 0)
//   halted     - sequencer is in HALT
//   retire_cnt - instructions completed, wrapping
//   dbg_state  - current state encoding for observation
//
// Handshake: an access is requested while memrq=1 and completes in the cycle
// mem_ready=1 is seen with it; mem_ready is ignored while memrq=0. During an
// incomplete access, register enables are suppressed and the state holds.
module mu0_seq
  import mu0_pkg::*;
#(
  parameter  int NIDX  = 4,
  parameter  int CNT_W = 16,
  localparam int IDX_W = $clog2(NIDX)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic [IDX_W-1:0] ir_idx,
  input  logic             accz,
  input  logic             acc15,
  input  logic             mem_ready,
  input  logic             resume,
  output logic             asel,
  output logic             bsel,
  output logic             accce,
  output logic             pcce,
  output logic             irce,
  output logic             accoe,
  output logic             memrq,
  output logic             rnw,
  output logic             idx_en,
  output logic             csel,
  output logic             idxce,
  output logic             idxoe,
  output logic             dsel,
  output logic [1:0]       alufs,
  output logic [IDX_W-1:0] idx_sel,
  output logic             halted,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [1:0]       dbg_state
);

  state_t            state_q;
  state_t            next_dec;
  state_t            state_d;
  ctrl_t             ctl_dec;
  ctrl_t             ctl;
  logic              stall;
  logic              retire;
  logic [CNT_W-1:0]  cnt_q;

  mu0_seq_decode u_decode (
    .state      (state_q),
    .opcode     (opcode),
    .accz       (accz),
    .acc15      (acc15),
    .resume     (resume),
    .ctl        (ctl_dec),
    .next_state (next_dec)
  );

  assign stall = ctl_dec.memrq & ~mem_ready;

  always_comb begin
    ctl = ctl_dec;
    if (stall) begin
      ctl.accce = 1'b0;
      ctl.pcce  = 1'b0;
      ctl.irce  = 1'b0;
      ctl.idxce = 1'b0;
    end
    if (!reset) ctl = '0;
  end

  assign state_d = stall ? state_q : next_dec;

  // An instruction retires when execution ends: EXEC moving anywhere but
  // EXEC2 (including the fused jump back into EXEC), or EXEC2 finishing.
  assign retire = !stall &&
                  ((state_q == ST_EXEC && next_dec != ST_EXEC2) ||
                   state_q == ST_EXEC2);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign asel       = ctl.asel;
  assign bsel       = ctl.bsel;
  assign accce      = ctl.accce;
  assign pcce       = ctl.pcce;
  assign irce       = ctl.irce;
  assign accoe      = ctl.accoe;
  assign memrq      = ctl.memrq;
  assign rnw        = ctl.rnw;
  assign idx_en     = ctl.idx_en;
  assign csel       = ctl.csel;
  assign idxce      = ctl.idxce;
  assign idxoe      = ctl.idxoe;
  assign dsel       = ctl.dsel;
  assign alufs      = ctl.alufs;
  assign idx_sel    = (reset && (state_q == ST_EXEC || state_q == ST_EXEC2)) ? ir_idx : '0;
  assign halted     = reset && (state_q == ST_HALT);
  assign retire_cnt = cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mu0_seq.sv
// tb_mu0_seq: cycle-level scoreboard bench for mu0_seq (NIDX=4, CNT_W=4).
module tb_mu0_seq;
  import mu0_pkg::*;

  localparam int NIDX  = 4;
  localparam int CNT_W = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             reset;
  logic [3:0]       opcode;
  logic [IDX_W-1:0] ir_idx;
  logic             accz, acc15, mem_ready, resume;
  logic             asel, bsel, accce, pcce, irce, accoe, memrq, rnw;
  logic             idx_en, csel, idxce, idxoe, dsel;
  logic [1:0]       alufs;
  logic [IDX_W-1:0] idx_sel;
  logic             halted;
  logic [CNT_W-1:0] retire_cnt;
  logic [1:0]       dbg_state;

  mu0_seq #(.NIDX(NIDX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .ir_idx(ir_idx),
    .accz(accz), .acc15(acc15), .mem_ready(mem_ready), .resume(resume),
    .asel(asel), .bsel(bsel), .accce(accce), .pcce(pcce), .irce(irce),
    .accoe(accoe), .memrq(memrq), .rnw(rnw), .idx_en(idx_en), .csel(csel),
    .idxce(idxce), .idxoe(idxoe), .dsel(dsel), .alufs(alufs),
    .idx_sel(idx_sel), .halted(halted), .retire_cnt(retire_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic asel, bsel, accce, pcce, irce, accoe, memrq, rnw;
    logic idx_en, csel, idxce, idxoe, dsel;
    logic [1:0] alufs;
    logic halted;
    logic [IDX_W-1:0] idx_sel;
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  logic [23:0]      exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] cnt_m;
  logic             skip_fetch;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = '0;
    o.asel = asel; o.bsel = bsel; o.accce = accce; o.pcce = pcce;
    o.irce = irce; o.accoe = accoe; o.memrq = memrq; o.rnw = rnw;
    o.idx_en = idx_en; o.csel = csel; o.idxce = idxce; o.idxoe = idxoe;
    o.dsel = dsel; o.alufs = alufs; o.halted = halted; o.idx_sel = idx_sel;
    o.state = dbg_state; o.cnt = retire_cnt;
    return o;
  endfunction

  function automatic obs_t base(input logic [1:0] st);
    obs_t e;
    e = '0;
    e.state = st;
    e.cnt = cnt_m;
    return e;
  endfunction

  // Expected EXEC controls with memory ready.
  function automatic obs_t exec_exp(input logic [3:0] op, input logic [IDX_W-1:0] idx,
                                    input logic z, input logic n);
    obs_t e;
    e = base(ST_EXEC);
    e.idx_sel = idx;
    e.asel = 1'b1;
    case (op)
      OP_LDA:    begin e.bsel = 1; e.accce = 1; e.memrq = 1; e.rnw = 1; e.alufs = 2'b00; end
      OP_ADD:    begin e.bsel = 1; e.accce = 1; e.memrq = 1; e.rnw = 1; e.alufs = 2'b10; end
      OP_SUB:    begin e.bsel = 1; e.accce = 1; e.memrq = 1; e.rnw = 1; e.alufs = 2'b11; end
      OP_STO:    begin e.accoe = 1; e.memrq = 1; end
      OP_JMP:    begin e.pcce = 1; e.irce = 1; e.alufs = 2'b01; e.memrq = 1; e.rnw = 1; end
      OP_JGE:    begin e.asel = !n; e.pcce = 1; e.irce = 1; e.alufs = 2'b01; e.memrq = 1; e.rnw = 1; end
      OP_JNE:    begin e.asel = !z; e.pcce = 1; e.irce = 1; e.alufs = 2'b01; e.memrq = 1; e.rnw = 1; end
      OP_STP:    e.asel = 1'b0;
      OP_MOVI:   begin e.accce = 1; e.idx_en = 1; e.alufs = 2'b00; end
      OP_MOVIDX: begin e.accoe = 1; e.idx_en = 1; e.idxce = 1; end
      OP_LDIDX:  begin e.bsel = 1; e.accce = 1; e.memrq = 1; e.rnw = 1; e.dsel = 1; end
      OP_STIDX:  begin e.accoe = 1; e.memrq = 1; e.dsel = 1; end
      OP_ADDIDX: begin e.idx_en = 1; e.idxce = 1; e.alufs = 2'b10; end
      OP_SUBIDX: begin e.idx_en = 1; e.idxce = 1; e.alufs = 2'b11; end
      OP_STOIDX: begin e.memrq = 1; e.idxoe = 1; end
      OP_BUBIDX: begin e.accce = 1; e.idx_en = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // One clock: push expectation, sample at the rising edge, compare, then
  // return just after the falling edge ready for the next input change.
  task automatic step(input string tag, input obs_t e);
    obs_t exp_v;
    exp_q.push_back(e);
    @(posedge clk);
    exp_v = obs_t'(exp_q.pop_front());
    check_val(tag, {8'h00, observe()}, {8'h00, exp_v});
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    cnt_m = '0;
    skip_fetch = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      resume = 1'($urandom_range(0, 1));
      step("reset", base(ST_FETCH));
    end
    reset = 1'b1;
  endtask

  task automatic do_fetch(input int waits);
    obs_t e;
    for (int i = 0; i <= waits; i++) begin
      e = base(ST_FETCH);
      e.alufs = 2'b01; e.memrq = 1; e.rnw = 1;
      mem_ready = (i == waits);
      resume = 1'($urandom_range(0, 1));
      if (mem_ready) begin e.pcce = 1; e.irce = 1; end
      step("fetch", e);
    end
  endtask

  task automatic do_halt(input int cycles);
    obs_t e;
    for (int i = 0; i < cycles; i++) begin
      e = base(ST_HALT);
      e.halted = 1'b1;
      resume = (i == cycles - 1);
      mem_ready = 1'($urandom_range(0, 1));
      step("halt", e);
    end
    resume = 1'b0;
  endtask

  task automatic do_exec(input logic [3:0] op, input logic [IDX_W-1:0] idx,
                         input logic z, input logic n, input int waits);
    obs_t e, ew;
    opcode = op; ir_idx = idx; accz = z; acc15 = n;
    resume = (op == OP_STP) ? 1'b1 : 1'($urandom_range(0, 1));
    e = exec_exp(op, idx, z, n);
    if (e.memrq) begin
      for (int i = 0; i < waits; i++) begin
        ew = e;
        ew.accce = 0; ew.pcce = 0; ew.irce = 0; ew.idxce = 0;
        mem_ready = 1'b0;
        step("exec_wait", ew);
      end
      mem_ready = 1'b1;
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    step("exec", e);
    if (op == OP_BUBIDX) begin
      e = base(ST_EXEC2);
      e.accce = 1; e.idx_en = 1; e.csel = 1; e.idx_sel = idx;
      mem_ready = 1'($urandom_range(0, 1));
      step("exec2", e);
    end
    cnt_m = cnt_m + 1'b1;
  endtask

  task automatic do_instr(input logic [3:0] op, input logic [IDX_W-1:0] idx,
                          input logic z, input logic n, input int fw, input int ew);
    opcode = op;
    if (!skip_fetch) do_fetch(fw);
    do_exec(op, idx, z, n, ew);
    skip_fetch = (op == OP_JMP || op == OP_JGE || op == OP_JNE);
    if (op == OP_STP) begin
      do_halt($urandom_range(1, 3));
      skip_fetch = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; opcode = OP_LDA; ir_idx = '0; accz = 0; acc15 = 0;
    mem_ready = 1'b1; resume = 1'b0; cnt_m = '0; skip_fetch = 1'b0;
    #2;
    do_reset(3);

    do_instr(OP_LDA, 2'd1, 0, 0, 0, 0);
    check_val("cnt_after_lda", 32'(retire_cnt), 32'd1);

    do_instr(OP_ADD, 2'd0, 0, 0, 2, 1);
    check_val("cnt_after_add", 32'(retire_cnt), 32'd2);

    do_instr(OP_JNE, 2'd0, 0, 0, 0, 0);   // taken: asel=1, stays in EXEC
    do_instr(OP_MOVI, 2'd2, 0, 0, 0, 0);
    do_instr(OP_JNE, 2'd0, 1, 0, 0, 0);   // not taken: asel=0
    do_instr(OP_LDA, 2'd0, 0, 0, 0, 0);
    do_instr(OP_JMP, 2'd0, 0, 0, 1, 2);
    do_instr(OP_JGE, 2'd0, 0, 1, 0, 0);
    do_instr(OP_SUB, 2'd3, 0, 0, 0, 0);

    do_instr(OP_BUBIDX, 2'd3, 0, 0, 0, 0);

    // STP with resume high in the same cycle, then four HALT cycles.
    opcode = OP_STP;
    do_fetch(0);
    do_exec(OP_STP, 2'd0, 0, 0, 0);
    do_halt(4);
    skip_fetch = 1'b0;

    for (int op = 0; op < 16; op++)
      do_instr(4'(op), 2'(op), 1'(op), 1'(op >> 1), op % 2, op % 3);

    for (int i = 0; i < 40; i++)
      do_instr(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 2), $urandom_range(0, 2));

    // Asynchronous reset in the middle of an EXEC wait state.
    if (skip_fetch) begin
      do_instr(OP_MOVI, 2'd0, 0, 0, 0, 0);
    end
    do_fetch(0);
    opcode = OP_LDA;
    mem_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_memrq", 32'(memrq), 32'd0);
    check_val("rst_cnt", 32'(retire_cnt), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'(ST_FETCH));
    @(negedge clk);
    #1;
    do_reset(2);

    // 16 retirements wrap a 4-bit counter to zero.
    for (int i = 0; i < 16; i++)
      do_instr(OP_MOVI, 2'(i), 0, 0, 0, 0);
    check_val("cnt_wrap", 32'(retire_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mu0_seq.md
# mu0_seq

Parametrised control sequencer for the MU0 indexed-accumulator CPU. It replaces the two-phase fetch/execute controller with an explicit state machine. New capabilities over the previous controller:
- memory wait states through a `mem_ready` handshake;
- a bank of `NIDX` index registers selected from the instruction;
- a two-phase BUBIDX compare/swap;
- halt with external resume;
- a retired-instruction counter.

It drives the datapath (PC, IR, ACC, index bank, ALU muxes) and the memory request lines.

## Interface
- `NIDX`, 4: number of index registers; power of two, ≥2.
- `IDX_W`, $clog2(NIDX): index select width (derived, not overridden).
- `CNT_W`, 16: retired-instruction counter width.

Ports:
- `clk` in 1: single clock. The state register updates on the falling edge; the datapath samples on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `opcode` in 4: IR[15:12].
- `ir_idx` in IDX_W: index register field from IR.
- `accz`, `acc15` in 1: ACC zero flag and sign flag.
- `mem_ready` in 1: memory has completed the current `memrq` access this cycle.
- `resume` in 1: leave HALT.
- `asel bsel accce pcce irce accoe memrq rnw idx_en csel idxce idxoe dsel` out 1: datapath and memory controls.
- `alufs` out 2: 00 pass B, 01 A+1, 10 A+B, 11 A−B.
- `idx_sel` out IDX_W: index register addressed.
- `halted` out 1: sequencer is in HALT.
- `retire_cnt` out CNT_W: instructions completed, modulo 2^CNT_W.

## Operation
- States: FETCH, EXEC, EXEC2, HALT. Encodings are defined in the package.
- Outputs are combinational from the state, `opcode`, flags and `mem_ready`. Any control not listed for a state/opcode is 0.
- FETCH:
  - asserts asel=0, alufs=01, pcce, irce, memrq, rnw=1.
  - Moves to EXEC when `mem_ready`=1.
- Wait rule: whenever `memrq`=1 and `mem_ready`=0, `accce`, `pcce`, `irce` and `idxce` are forced to 0 and the state holds.
- EXEC per opcode, with asel=1 unless stated:
  - LDA, ADD, SUB: bsel=1, accce, memrq, rnw=1; alufs 00 / 10 / 11 respectively.
  - STO: accoe, memrq, rnw=0.
  - JMP, JGE taken (acc15=0), JNE taken (accz=0): pcce, irce, alufs=01, memrq, rnw=1. This is a fused target fetch; next state is EXEC.
  - JGE/JNE not taken: same controls with asel=0 (sequential fetch); next state is EXEC.
  - STP: no controls asserted; next state HALT.
  - MOVI: accce, alufs=00, idx_en.
  - MOVIDX: accoe, idx_en, idxce.
  - LDIDX: as LDA plus dsel.
  - STIDX: as STO plus dsel.
  - ADDIDX, SUBIDX: idx_en, idxce; alufs 10 / 11.
  - STOIDX: memrq, rnw=0, idxoe.
  - BUBIDX: accce, idx_en (compare phase); next state EXEC2.
- EXEC2 (BUBIDX only): accce, idx_en, csel (swap phase); next state FETCH.
- All other EXEC completions go to FETCH. For memory opcodes, completion waits for `mem_ready`.
- `idx_sel` = `ir_idx` in EXEC/EXEC2, 0 otherwise.
- HALT:
  - `halted`=1 and all controls are 0.
  - `resume`=1 on a falling edge moves to FETCH. `resume` is ignored in every other state.
- `retire_cnt` increments by 1 on each falling edge that leaves EXEC or EXEC2 toward FETCH, HALT or EXEC (fused jump). It wraps at 2^CNT_W − 1 → 0.

## Timing
- Reset asserted: state=FETCH, `retire_cnt`=0, `halted`=0.
  - All controls are forced to 0 combinationally, including memrq; alufs=00; idx_sel=0.
  - The first fetch request appears in the cycle after reset deasserts.
- Reset during a wait state or EXEC2 abandons the instruction. No partial count is recorded.
- Zero-wait memory: 2 cycles per instruction; BUBIDX takes 3; taken jumps take 1 extra EXEC, not an extra FETCH.
- Each `mem_ready`-low cycle adds exactly one cycle. `mem_ready` is sampled only while `memrq`=1.
- `resume` and STP in the same cycle: the sequencer enters HALT; the `resume` is lost.

## Structure
- Package `mu0_pkg` holds:
  - the 4-bit opcode constants (LDA 0 … BUBIDX 15);
  - the alufs codes;
  - the state enum.
- One sub-module, `mu0_seq_decode`: a purely combinational table of state, opcode and flags → control vector and next state.
- The top level holds the state register, the wait gating, and the retire counter.

## Test plan
- Reset low 3 cycles, release, LDA with `mem_ready`=1 → FETCH then EXEC; accce pulses in EXEC with alufs=00; `retire_cnt`=1.
- ADD with `mem_ready` low 2 cycles in FETCH and 1 cycle in EXEC → irce/pcce/accce stay 0 while low; instruction completes in 5 cycles; count +1.
- JNE with accz=0 → asel=1, pcce=1, next state EXEC. JNE with accz=1 → asel=0.
- BUBIDX with `ir_idx`=3, NIDX=4 → idx_sel=3 in EXEC and EXEC2; csel=1 only in EXEC2; 3-cycle instruction.
- STP then `resume` 4 cycles later → `halted`=1 for exactly those cycles; FETCH follows; STP is counted once.
- CNT_W=4: 16 instructions → `retire_cnt` wraps to 0. Reset mid-EXEC → count=0 and memrq=0 immediately.
